// File: rtl/seq_stim_gen_if.sv
// Bundle of pattern-load, step-button and serial-output signals for seq_stim_gen.
// The master side drives pattern/load/step; the slave side (the generator) drives
// the serial bit, its strobe and the progress indicators.
interface seq_stim_gen_if #(
    parameter int WIDTH = 8
);
    localparam int LW = $clog2(WIDTH + 1);

    logic             load;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic             loop;
    logic             step_btn;
    logic             out;
    logic             out_clk;
    logic             busy;
    logic             done;
    logic [LW-1:0]    remaining;

    modport master (
        output load, pattern, len, loop, step_btn,
        input  out, out_clk, busy, done, remaining
    );

    modport slave (
        input  load, pattern, len, loop, step_btn,
        output out, out_clk, busy, done, remaining
    );
endinterface

// File: rtl/seq_stim_gen.sv
// Serial stimulus generator: loads a pattern from switches and emits it MSB-first,
// one bit per debounced button press, each bit followed by a one-cycle strobe that
// clocks the downstream sequence detector.
module seq_stim_gen #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_stim_gen_if.slave     bus
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
    localparam logic [LW-1:0] ZERO_L  = LW'(0);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] shreg_q, save_q;
    logic [LW-1:0]    len_q, remaining_q;
    logic             loop_q;
    logic             out_q, out_clk_q, emit_q;
    logic             busy_q, done_q;

    logic             step_pulse_s;
    logic [LW-1:0]    len_eff_d;
    logic [WIDTH-1:0] pattern_al_d;

    // Synchronize the raw button and keep one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.step_btn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // One-cycle pulse per synchronized rising edge, however long the button is held.
    assign step_pulse_s = s2_q & ~s3_q;

    // Clamp the requested length and left-align the used bits so the first bit is the MSB.
    always_comb begin
        len_eff_d = WIDTH_L;
        if ((bus.len == ZERO_L) || (bus.len > WIDTH_L)) begin
            len_eff_d = WIDTH_L;
        end else begin
            len_eff_d = bus.len;
        end
        pattern_al_d = bus.pattern << (WIDTH_L - len_eff_d);
    end

    // Control FSM with registered outputs; load always wins over a step in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            save_q      <= '0;
            len_q       <= ZERO_L;
            remaining_q <= ZERO_L;
            loop_q      <= 1'b0;
            out_q       <= 1'b0;
            emit_q      <= 1'b0;
            out_clk_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // The strobe trails the bit by one cycle so the detector sees a settled input.
            out_clk_q <= emit_q;
            emit_q    <= 1'b0;
            if (bus.load) begin
                shreg_q     <= pattern_al_d;
                save_q      <= pattern_al_d;
                len_q       <= len_eff_d;
                loop_q      <= bus.loop;
                remaining_q <= len_eff_d;
                state_q     <= ARMED;
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
            end else begin
                case (state_q)
                    ARMED, SHIFT: begin
                        if (step_pulse_s) begin
                            out_q  <= shreg_q[WIDTH-1];
                            emit_q <= 1'b1;
                            if (remaining_q == ONE_L) begin
                                if (loop_q) begin
                                    shreg_q     <= save_q;
                                    remaining_q <= len_q;
                                    state_q     <= SHIFT;
                                    busy_q      <= 1'b1;
                                    done_q      <= 1'b0;
                                end else begin
                                    shreg_q     <= shreg_q << 1;
                                    remaining_q <= ZERO_L;
                                    state_q     <= DONE;
                                    busy_q      <= 1'b0;
                                    done_q      <= 1'b1;
                                end
                            end else begin
                                shreg_q     <= shreg_q << 1;
                                remaining_q <= remaining_q - ONE_L;
                                state_q     <= SHIFT;
                                busy_q      <= 1'b1;
                                done_q      <= 1'b0;
                            end
                        end else begin
                            state_q <= state_q;
                        end
                    end
                    IDLE, DONE: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_clk   = out_clk_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = remaining_q;
endmodule

// File: tb/tb_seq_stim_gen.sv
// Directed bench for seq_stim_gen: loads patterns, presses the step button and
// compares the serial bit, strobe and progress outputs against hand-computed values.
module tb_seq_stim_gen;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_stim_gen_if #(.WIDTH(8)) bus ();

    seq_stim_gen #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load a pattern with a one-cycle load pulse.
    task automatic do_load(input logic [7:0] pat, input logic [3:0] ln, input logic lp);
        @(negedge clk);
        bus.pattern = pat;
        bus.len     = ln;
        bus.loop    = lp;
        bus.load    = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    // One button press; watch 8 edges, counting strobes and capturing out at the strobe.
    task automatic press(output int nclk, output logic obit);
        nclk = 0;
        obit = 1'bx;
        @(negedge clk);
        bus.step_btn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) bus.step_btn = 1'b0;
            if (bus.out_clk === 1'b1) begin
                nclk++;
                obit = bus.out;
            end
        end
    endtask

    int          nclk;
    int          tot;
    int          first_k;
    logic        obit;
    logic [7:0]  pat_v;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.load = 1'b0; bus.pattern = 8'h00; bus.len = 4'd0; bus.loop = 1'b0; bus.step_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out",  32'(bus.out),       32'd0);
        chk("rst_busy", 32'(bus.busy),      32'd0);
        chk("rst_rem",  32'(bus.remaining), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Full pattern, no loop
        pat_v = 8'b1011_0010;
        do_load(pat_v, 4'd8, 1'b0);
        chk("load_busy", 32'(bus.busy),      32'd1);
        chk("load_rem",  32'(bus.remaining), 32'd8);
        chk("load_done", 32'(bus.done),      32'd0);
        for (int i = 0; i < 8; i++) begin
            press(nclk, obit);
            chk("full_nclk", 32'(nclk),          32'd1);
            chk("full_bit",  32'(obit),          32'(pat_v[7-i]));
            chk("full_rem",  32'(bus.remaining), 32'(7 - i));
            chk("full_done", 32'(bus.done),      (i == 7) ? 32'd1 : 32'd0);
        end
        press(nclk, obit);
        chk("full_9th_nclk", 32'(nclk),     32'd0);
        chk("full_9th_done", 32'(bus.done), 32'd1);

        // Short pattern: low 3 bits 110
        do_load(8'b1111_0110, 4'd3, 1'b0);
        chk("short_done_drop", 32'(bus.done), 32'd0);
        pat_v = 8'b1100_0000;
        for (int i = 0; i < 3; i++) begin
            press(nclk, obit);
            chk("short_bit", 32'(obit), 32'(pat_v[7-i]));
        end
        chk("short_done", 32'(bus.done), 32'd1);

        // len=0 sends all 8 bits
        pat_v = 8'b1011_0010;
        do_load(pat_v, 4'd0, 1'b0);
        chk("len0_rem", 32'(bus.remaining), 32'd8);
        for (int i = 0; i < 8; i++) begin
            press(nclk, obit);
            chk("len0_bit", 32'(obit), 32'(pat_v[7-i]));
        end
        chk("len0_done", 32'(bus.done), 32'd1);

        // len=12 clamps to 8 bits
        pat_v = 8'h5A;
        do_load(pat_v, 4'd12, 1'b0);
        chk("len12_rem", 32'(bus.remaining), 32'd8);
        for (int i = 0; i < 8; i++) begin
            press(nclk, obit);
            chk("len12_bit", 32'(obit), 32'(pat_v[7-i]));
        end
        chk("len12_done", 32'(bus.done), 32'd1);

        // Loop: 2-bit pattern 10 repeated
        do_load(8'b0000_0010, 4'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            press(nclk, obit);
            chk("loop_bit",  32'(obit),          (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("loop_rem",  32'(bus.remaining), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("loop_done", 32'(bus.done),      32'd0);
        end

        // Button hold: one strobe, 4 edges after the rise
        do_load(8'hFF, 4'd8, 1'b0);
        tot = 0;
        first_k = -1;
        @(negedge clk);
        bus.step_btn = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_clk === 1'b1) begin
                tot++;
                if (first_k < 0) first_k = k;
            end
        end
        bus.step_btn = 1'b0;
        chk("hold_nclk", 32'(tot),           32'd1);
        chk("hold_edge", 32'(first_k),       32'd3);
        chk("hold_rem",  32'(bus.remaining), 32'd7);
        repeat (4) @(posedge clk);

        // Collision: load and step pulse in the same cycle while shifting
        do_load(8'b1011_0010, 4'd8, 1'b0);
        press(nclk, obit);
        chk("coll_pre_bit", 32'(obit), 32'd1);
        @(negedge clk);
        bus.step_btn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.pattern = 8'b0000_0011;
        bus.len     = 4'd3;
        bus.loop    = 1'b0;
        bus.load    = 1'b1;
        @(posedge clk);
        #1;
        bus.load     = 1'b0;
        bus.step_btn = 1'b0;
        chk("coll_rem", 32'(bus.remaining), 32'd3);
        chk("coll_out", 32'(bus.out),       32'd1);
        tot = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_clk === 1'b1) tot++;
        end
        chk("coll_nclk", 32'(tot), 32'd0);
        press(nclk, obit);
        chk("coll_new_nclk", 32'(nclk), 32'd1);
        chk("coll_new_bit",  32'(obit), 32'd0);
        chk("coll_new_rem",  32'(bus.remaining), 32'd2);

        // Asynchronous reset mid-pattern, between clock edges
        do_load(8'hFF, 4'd8, 1'b0);
        press(nclk, obit);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out",     32'(bus.out),       32'd0);
        chk("arst_out_clk", 32'(bus.out_clk),   32'd0);
        chk("arst_busy",    32'(bus.busy),      32'd0);
        chk("arst_done",    32'(bus.done),      32'd0);
        chk("arst_rem",     32'(bus.remaining), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tot = 0;
        for (int i = 0; i < 3; i++) begin
            press(nclk, obit);
            tot += nclk;
        end
        chk("arst_press_nclk", 32'(tot),      32'd0);
        chk("arst_idle_busy",  32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
